// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Two-client (I-cache / D-cache) arbiter for a single main
//                memory port. Round-robin on ties, request fields latched on
//                grant, one-cycle RELEASE gap between transactions.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              proc_reset,
    // I-cache side
    input  logic              i_mem_read,
    input  logic [ADDR_W-1:0] i_mem_addr,
    output logic [DATA_W-1:0] i_mem_rdata,
    output logic              i_mem_ready,
    // D-cache side
    input  logic              d_mem_read,
    input  logic              d_mem_write,
    input  logic [ADDR_W-1:0] d_mem_addr,
    input  logic [DATA_W-1:0] d_mem_wdata,
    output logic [DATA_W-1:0] d_mem_rdata,
    output logic              d_mem_ready,
    // main memory side
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    // status
    output logic              grant_d,
    output logic              arb_busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_I   = 2'd1,
        GNT_D   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic                r_last_d;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_write;

    logic                w_i_req;
    logic                w_d_req;
    logic                w_pick_d;
    logic                w_granting;

    assign w_i_req    = i_mem_read;
    assign w_d_req    = d_mem_read | d_mem_write;
    // D wins when it is the only requester, or on a tie when I was served last
    assign w_pick_d   = w_d_req & ~(w_i_req & r_last_d);
    assign w_granting = (r_state == IDLE) & (w_i_req | w_d_req);

    // State register and round-robin history
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            r_state  <= IDLE;
            r_last_d <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (r_state == GNT_D && mem_ready) begin
                r_last_d <= 1'b1;
            end else if (r_state == GNT_I && mem_ready) begin
                r_last_d <= 1'b0;
            end
        end
    end

    // Next-state logic; a dropped request never aborts an open transaction
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_granting) begin
                    w_next_state = w_pick_d ? GNT_D : GNT_I;
                end
            end
            GNT_I, GNT_D: begin
                if (mem_ready) begin
                    w_next_state = RELEASE;
                end
            end
            RELEASE: w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Latch the winner's request fields; write has priority over read on D
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_write <= 1'b0;
        end else if (w_granting) begin
            if (w_pick_d) begin
                r_addr  <= d_mem_addr;
                r_wdata <= d_mem_wdata;
                r_write <= d_mem_write;
            end else begin
                r_addr  <= i_mem_addr;
                r_wdata <= '0;
                r_write <= 1'b0;
            end
        end
    end

    // Memory and client outputs driven purely from state and latched fields
    always_comb begin
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        i_mem_ready = 1'b0;
        d_mem_ready = 1'b0;
        if (r_state == GNT_I || r_state == GNT_D) begin
            mem_read  = ~r_write;
            mem_write = r_write;
        end
        if (r_state == GNT_I) begin
            i_mem_ready = mem_ready;
        end
        if (r_state == GNT_D) begin
            d_mem_ready = mem_ready;
        end
    end

    assign mem_addr    = r_addr;
    assign mem_wdata   = r_wdata;
    assign i_mem_rdata = mem_rdata;
    assign d_mem_rdata = mem_rdata;
    assign grant_d     = (r_state == GNT_D);
    assign arb_busy    = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Self-checking bench for mem_arbiter: directed scenarios with
//                literal expectations plus randomized traffic compared every
//                cycle against a transaction-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int ADDR_W = 28;
    localparam int DATA_W = 128;

    logic              clk = 1'b0;
    logic              proc_reset;
    logic              i_mem_read;
    logic [ADDR_W-1:0] i_mem_addr;
    logic [DATA_W-1:0] i_mem_rdata;
    logic              i_mem_ready;
    logic              d_mem_read;
    logic              d_mem_write;
    logic [ADDR_W-1:0] d_mem_addr;
    logic [DATA_W-1:0] d_mem_wdata;
    logic [DATA_W-1:0] d_mem_rdata;
    logic              d_mem_ready;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic              grant_d;
    logic              arb_busy;

    int n_tests = 0;
    int n_fail  = 0;
    bit check_en = 1'b0;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .proc_reset(proc_reset),
        .i_mem_read(i_mem_read), .i_mem_addr(i_mem_addr),
        .i_mem_rdata(i_mem_rdata), .i_mem_ready(i_mem_ready),
        .d_mem_read(d_mem_read), .d_mem_write(d_mem_write),
        .d_mem_addr(d_mem_addr), .d_mem_wdata(d_mem_wdata),
        .d_mem_rdata(d_mem_rdata), .d_mem_ready(d_mem_ready),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .grant_d(grant_d), .arb_busy(arb_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Transaction-level model: phase 0 = free, 1 = serving, 2 = gap cycle
    // ------------------------------------------------------------------
    int                m_phase;
    bit                m_owner_d;
    bit                m_last_d;
    bit                m_wr;
    bit                m_fresh;      // no grant since last reset
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;

    function automatic bit model_picks_d(bit ireq, bit dreq, bit last_d);
        if (dreq && !ireq) return 1'b1;
        if (ireq && !dreq) return 1'b0;
        return !last_d;   // tie: the client not served last
    endfunction

    // Model advances on each rising edge from the inputs present there
    always @(posedge clk) begin
        if (proc_reset) begin
            m_phase  <= 0;
            m_last_d <= 1'b0;
            m_wr     <= 1'b0;
            m_addr   <= '0;
            m_wdata  <= '0;
            m_fresh  <= 1'b1;
        end else if (m_phase == 0) begin
            if (i_mem_read || d_mem_read || d_mem_write) begin
                m_phase   <= 1;
                m_fresh   <= 1'b0;
                m_owner_d <= model_picks_d(i_mem_read, d_mem_read | d_mem_write, m_last_d);
                if (model_picks_d(i_mem_read, d_mem_read | d_mem_write, m_last_d)) begin
                    m_addr  <= d_mem_addr;
                    m_wdata <= d_mem_wdata;
                    m_wr    <= d_mem_write;
                end else begin
                    m_addr  <= i_mem_addr;
                    m_wr    <= 1'b0;
                end
            end
        end else if (m_phase == 1) begin
            if (mem_ready) begin
                m_phase  <= 2;
                m_last_d <= m_owner_d;
            end
        end else begin
            m_phase <= 0;
        end
    end

    // Compare process: every cycle, mid-way between rising edges
    always @(negedge clk) begin
        if (check_en) begin
            bit serving;
            serving = (m_phase == 1);
            chk("mem_read",    mem_read,    serving && !m_wr);
            chk("mem_write",   mem_write,   serving && m_wr);
            chk("grant_d",     grant_d,     serving && m_owner_d);
            chk("arb_busy",    arb_busy,    m_phase != 0);
            chk("i_mem_ready", i_mem_ready, serving && !m_owner_d && mem_ready);
            chk("d_mem_ready", d_mem_ready, serving && m_owner_d && mem_ready);
            chk("i_mem_rdata", i_mem_rdata, mem_rdata);
            chk("d_mem_rdata", d_mem_rdata, mem_rdata);
            if (m_fresh)
                chk("mem_addr_rst", mem_addr, '0);
            else if (serving)
                chk("mem_addr", mem_addr, m_addr);
            if (m_fresh)
                chk("mem_wdata_rst", mem_wdata, '0);
            else if (serving && m_wr)
                chk("mem_wdata", mem_wdata, m_wdata);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATA_W-1:0] wd;
        bit                seen;
        proc_reset = 1'b1;
        i_mem_read = 0; i_mem_addr = '0;
        d_mem_read = 0; d_mem_write = 0; d_mem_addr = '0; d_mem_wdata = '0;
        mem_rdata = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210; mem_ready = 0;
        tick();
        check_en = 1'b1;
        tick();
        @(negedge clk);
        chk("rst_mem_read", mem_read, 0);
        chk("rst_arb_busy", arb_busy, 0);
        chk("rst_mem_addr", mem_addr, 0);
        proc_reset = 1'b0;

        // I-only read, memory answers on the third grant cycle
        tick();
        i_mem_read = 1; i_mem_addr = 28'h0000010;
        tick();
        @(negedge clk);
        chk("i_only_mem_read", mem_read, 1);
        chk("i_only_mem_addr", mem_addr, 28'h0000010);
        tick(); tick();
        mem_ready = 1;
        @(negedge clk);
        chk("i_only_i_ready", i_mem_ready, 1);
        chk("i_only_d_ready", d_mem_ready, 0);
        tick();
        i_mem_read = 0; mem_ready = 0;
        @(negedge clk);
        chk("i_only_release_busy", arb_busy, 1);
        chk("i_only_release_rd", mem_read, 0);
        tick();
        @(negedge clk);
        chk("i_only_idle_busy", arb_busy, 0);

        // Tie with last_d = 0: D first, then I
        i_mem_read = 1; i_mem_addr = 28'h1;
        d_mem_read = 1; d_mem_addr = 28'h2;
        tick();
        @(negedge clk);
        chk("tie1_grant_d", grant_d, 1);
        chk("tie1_addr", mem_addr, 28'h2);
        mem_ready = 1;
        tick();
        d_mem_read = 0; mem_ready = 0;
        tick();
        tick();
        @(negedge clk);
        chk("tie2_grant_d", grant_d, 0);
        chk("tie2_addr", mem_addr, 28'h1);
        chk("tie2_mem_read", mem_read, 1);
        mem_ready = 1;
        tick();
        i_mem_read = 0; mem_ready = 0;
        tick();

        // D write-back with inputs changing mid-grant
        wd = 128'hDEAD_BEEF_CAFE_F00D_1234_5678_9ABC_DEF0;
        d_mem_write = 1; d_mem_addr = 28'h55; d_mem_wdata = wd;
        tick();
        d_mem_addr = 28'h99; d_mem_wdata = ~wd;
        repeat (2) begin
            @(negedge clk);
            chk("wb_mem_write", mem_write, 1);
            chk("wb_mem_addr", mem_addr, 28'h55);
            chk("wb_mem_wdata", mem_wdata, wd);
            tick();
        end
        mem_ready = 1;
        tick();
        d_mem_write = 0; mem_ready = 0;
        tick();

        // Reset in the middle of a D grant
        d_mem_read = 1; d_mem_addr = 28'h77;
        tick();
        proc_reset = 1; d_mem_read = 0;
        tick();
        proc_reset = 0;
        @(negedge clk);
        chk("midrst_busy", arb_busy, 0);
        chk("midrst_mem_read", mem_read, 0);
        chk("midrst_grant_d", grant_d, 0);
        chk("midrst_addr", mem_addr, 0);

        // Continuous requests from both: D, I, D, I
        i_mem_read = 1; i_mem_addr = 28'h3;
        d_mem_read = 1; d_mem_addr = 28'h4;
        for (int k = 0; k < 4; k++) begin
            seen = 0;
            for (int w = 0; w < 5 && !seen; w++) begin
                tick();
                @(negedge clk);
                seen = mem_read;
            end
            chk("rr_grant_seen", seen, 1);
            chk("rr_grant_d", grant_d, (k % 2 == 0));
            chk("rr_addr", mem_addr, (k % 2 == 0) ? 28'h4 : 28'h3);
            #2 mem_ready = 1;
            #1;
            chk("rr_d_ready", d_mem_ready, (k % 2 == 0));
            chk("rr_i_ready", i_mem_ready, (k % 2 == 1));
            tick();
            mem_ready = 0;
        end
        i_mem_read = 0; d_mem_read = 0;
        tick(); tick();

        // Spurious mem_ready while idle
        mem_ready = 1;
        repeat (3) begin
            tick();
            @(negedge clk);
            chk("spur_busy", arb_busy, 0);
            chk("spur_i_ready", i_mem_ready, 0);
            chk("spur_d_ready", d_mem_ready, 0);
        end
        mem_ready = 0;

        // Randomized traffic checked by the model every cycle
        for (int c = 0; c < 4000; c++) begin
            tick();
            proc_reset  = ($urandom_range(0, 299) == 0);
            i_mem_read  = ($urandom_range(0, 2) != 0);
            d_mem_read  = ($urandom_range(0, 2) != 0);
            d_mem_write = ($urandom_range(0, 3) == 0);
            i_mem_addr  = ADDR_W'($urandom);
            d_mem_addr  = ADDR_W'($urandom);
            d_mem_wdata = {$urandom, $urandom, $urandom, $urandom};
            mem_rdata   = {$urandom, $urandom, $urandom, $urandom};
            mem_ready   = ($urandom_range(0, 2) == 0);
        end
        tick();
        check_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 28, block address width shared by the cache memory ports and main memory.
REQ-002 Parameter DATA_W, default 128, block data width.
REQ-003 The block SHALL have one clock, clk; reset SHALL be proc_reset, synchronous and active-high.
REQ-004 clk  in  1  system clock, all state updates on rising edge.
REQ-005 proc_reset  in  1  synchronous active-high reset.
REQ-006 i_mem_read  in  1  I-cache block read request, held until served.
REQ-007 i_mem_addr  in  ADDR_W  I-cache block address.
REQ-008 i_mem_rdata  out  DATA_W  read data to I-cache.
REQ-009 i_mem_ready  out  1  I-cache transfer complete.
REQ-010 d_mem_read  in  1  D-cache block read request.
REQ-011 d_mem_write  in  1  D-cache block write-back request.
REQ-012 d_mem_addr  in  ADDR_W  D-cache block address.
REQ-013 d_mem_wdata  in  DATA_W  D-cache write-back data.
REQ-014 d_mem_rdata  out  DATA_W  read data to D-cache.
REQ-015 d_mem_ready  out  1  D-cache transfer complete.
REQ-016 mem_read, mem_write  out  1 each  request to main memory.
REQ-017 mem_addr  out  ADDR_W; mem_wdata  out  DATA_W  latched request fields.
REQ-018 mem_rdata  in  DATA_W; mem_ready  in  1  main memory response.
REQ-019 grant_d  out  1  high while the D-cache owns memory; arb_busy  out  1  high in any non-IDLE state.

Function
REQ-020 FSM states SHALL be IDLE, GNT_I, GNT_D and RELEASE.
REQ-021 IDLE: i-request only -> GNT_I; d-request only (read or write) -> GNT_D; neither -> stay.
REQ-022 Both requesting in IDLE: grant the client not served last (round-robin bit last_d); last_d resets to 0, so D-cache wins the first tie.
REQ-023 On entering a GNT state, addr, wdata and op (read/write) of the winner SHALL be latched; mem_addr, mem_wdata and mem_read/mem_write SHALL come only from these registers.
REQ-024 Latency: a request sampled in IDLE at edge t SHALL drive mem_read/mem_write high in the cycle following t.
REQ-025 d_mem_read and d_mem_write both high SHALL latch as write; a single grant serves one operation.
REQ-026 In a GNT state, mem_read/mem_write SHALL stay asserted until mem_ready is sampled high, then the FSM moves to RELEASE and last_d is updated (1 for GNT_D, 0 for GNT_I).
REQ-027 The granted client's *_mem_ready SHALL equal mem_ready combinationally during its GNT state; the other client's ready SHALL be 0.
REQ-028 i_mem_rdata and d_mem_rdata SHALL both equal mem_rdata at all times; only the ready signal qualifies data.
REQ-029 RELEASE SHALL last exactly one cycle with mem_read = mem_write = 0 and both client readies 0, ignoring all requests, then return to IDLE.
REQ-030 A client's request dropping during its own GNT state SHALL NOT abort the memory transaction.
REQ-031 mem_ready high while in IDLE or RELEASE SHALL be ignored.
REQ-032 No client SHALL wait more than one other transaction when both request continuously.

Reset
REQ-033 proc_reset high at an edge SHALL force IDLE, last_d=0, latched addr/wdata/op = 0, from any state including mid-transaction.
REQ-034 During and after reset, before any grant: mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, i_mem_ready=0, d_mem_ready=0, grant_d=0, arb_busy=0.

Verification
REQ-035 I-only: i_mem_read=1, addr 0x0000010 -> next cycle mem_read=1, mem_addr=0x0000010; mem_ready after 3 cycles -> i_mem_ready=1 that cycle, RELEASE, IDLE.
REQ-036 Tie after reset: i and d read at 0x1/0x2 same cycle -> GNT_D first (mem_addr=0x2), then GNT_I (mem_addr=0x1) after RELEASE.
REQ-037 D write-back: d_mem_write=1, wdata=0xDEADBEEF_...; d_mem_addr changes mid-grant -> mem_addr/mem_wdata stay at latched values, mem_write=1 until mem_ready.
REQ-038 Continuous both-request for 4 transactions -> grant order D,I,D,I; d_mem_ready never asserted during GNT_I.
REQ-039 proc_reset asserted in GNT_D with mem_ready=0 -> next cycle all outputs 0, state IDLE; subsequent tie grants D.
REQ-040 Spurious mem_ready in IDLE -> no client ready, no state change.
